// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch control slice:
//   - fetch_state_e       : IF/ID controller FSM state encoding
//   - FETCH_CNT_W         : default width of the performance counters
//   - FETCH_MISS_TIMEOUT  : default number of MISS cycles before a fatal timeout
//   - tmo_width()         : width of a counter able to hold 0..timeout-1
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_REFILL = 2'd2,
    ST_ERR    = 2'd3
  } fetch_state_e;

  localparam int FETCH_CNT_W        = 16;
  localparam int FETCH_MISS_TIMEOUT = 64;

  // A timeout of 1 still needs a one-bit counter so the vector is never empty.
  function automatic int tmo_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage : fetch_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  1      clock
//   rst_n  in  1      asynchronous active-low reset, clears the count
//   inc    in  1      add one this cycle (ignored once saturated)
//   clear  in  1      synchronous clear, wins over inc
//   count  out WIDTH  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/if_id_ctrl.sv
// -----------------------------------------------------------------------------
// if_id_ctrl
// Fetch-stage controller: decides PC advance, IF/ID load/hold/bubble and drives
// instruction-cache refill requests, with a watchdog that parks the front end
// in a terminal error state if a refill never completes.
// Parameters:
//   MISS_TIMEOUT  MISS cycles tolerated before the fatal timeout
//   CNT_W         width of the stall / miss performance counters
// Ports:
//   clk           in  1      clock
//   rst_n         in  1      asynchronous active-low reset
//   icache_hit    in  1      fetch-stage instruction valid this cycle
//   icache_ready  in  1      refill complete (one-cycle pulse)
//   lw_stall      in  1      load-use hazard from ID
//   branch_taken  in  1      redirect from EX
//   pc_write      out 1      PC register enable
//   ifid_write    out 1      IF/ID load enable
//   ifid_flush    out 1      IF/ID loads a bubble
//   icache_req    out 1      refill request (asserted for the whole MISS state)
//   fetch_err     out 1      sticky miss-timeout flag
//   stall_cnt     out CNT_W  saturating count of cycles the PC did not advance
//   miss_cnt      out CNT_W  saturating count of cache misses
//   state_o       out 2      current FSM state
// -----------------------------------------------------------------------------
module if_id_ctrl
  import fetch_pkg::*;
#(
  parameter int MISS_TIMEOUT = FETCH_MISS_TIMEOUT,
  parameter int CNT_W        = FETCH_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_hit,
  input  logic             icache_ready,
  input  logic             lw_stall,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             icache_req,
  output logic             fetch_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [1:0]       state_o
);

  localparam int            TMO_W    = tmo_width(MISS_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MISS_TIMEOUT - 1);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             miss_inc;
  logic             stall_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        // A redirect discards the current fetch, so a miss on it is irrelevant.
        if (!branch_taken && !icache_hit) begin
          state_nxt = ST_MISS;
        end
      end
      ST_MISS: begin
        if (branch_taken) begin
          state_nxt = ST_RUN;
        end else if (icache_ready) begin
          state_nxt = ST_REFILL;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_ERR;
        end
      end
      ST_REFILL: state_nxt = ST_RUN;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Output decode. The reset term keeps the pipeline frozen with a bubble in
  // IF/ID for as long as rst_n is low, independent of the fetch inputs.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b1;
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            pc_write   = 1'b1;
          end else if (!icache_hit) begin
            pc_write   = 1'b0;
          end else if (lw_stall) begin
            ifid_flush = 1'b0;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
          end
        end
        ST_MISS: begin
          // An aborted miss still redirects the PC; the cache tolerates the
          // request vanishing on the following cycle.
          pc_write = branch_taken;
        end
        default: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
        end
      endcase
    end
  end

  // Moore outputs: both follow the state register, so an asynchronous reset
  // drops them immediately.
  assign icache_req = (state == ST_MISS);
  assign fetch_err  = (state == ST_ERR);
  assign state_o    = state;

  // Timeout counter: only runs while staying in MISS, so every exit (ready,
  // redirect, timeout) leaves it at zero for the next miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_MISS && state_nxt == ST_MISS) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign miss_inc  = (state == ST_RUN) && !branch_taken && !icache_hit;
  assign stall_inc = !pc_write && (state != ST_ERR);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .clear (1'b0),
    .count (miss_cnt)
  );

endmodule : if_id_ctrl

// File: tb/tb_if_id_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_id_ctrl
// Two controllers share one set of inputs: one with default parameters and one
// with 4-bit counters so saturation is reachable in a short run. A reference
// model describes the fetch front end in terms of "missing for N cycles",
// "refilling" and "dead" and is compared against both DUTs on every negedge.
// -----------------------------------------------------------------------------
module tb_if_id_ctrl;

  localparam int TO   = 64;
  localparam int MAXA = 65535;
  localparam int MAXB = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic icache_hit = 1'b1;
  logic icache_ready = 1'b0;
  logic lw_stall = 1'b0;
  logic branch_taken = 1'b0;

  logic        pw_a, iw_a, fl_a, req_a, err_a;
  logic [15:0] stall_a, miss_a;
  logic [1:0]  st_a;
  logic        pw_b, iw_b, fl_b, req_b, err_b;
  logic [3:0]  stall_b, miss_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .icache_ready(icache_ready),
    .lw_stall(lw_stall), .branch_taken(branch_taken),
    .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(fl_a), .icache_req(req_a),
    .fetch_err(err_a), .stall_cnt(stall_a), .miss_cnt(miss_a), .state_o(st_a)
  );

  if_id_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .icache_ready(icache_ready),
    .lw_stall(lw_stall), .branch_taken(branch_taken),
    .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(fl_b), .icache_req(req_b),
    .fetch_err(err_b), .stall_cnt(stall_b), .miss_cnt(miss_b), .state_o(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_dead, m_refill;
  int m_age;              // cycles spent waiting on the current miss, -1 if none
  int m_stall_a, m_stall_b, m_miss_a, m_miss_b;

  logic e_pw, e_iw, e_fl, e_req, e_err;
  logic [1:0] e_st;

  always_comb begin
    e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b1; e_req = 1'b0; e_err = 1'b0; e_st = 2'd0;
    if (rst_n) begin
      if (m_dead) begin
        e_err = 1'b1; e_st = 2'd3;
      end else if (m_refill) begin
        e_st = 2'd2;
      end else if (m_age >= 0) begin
        e_req = 1'b1; e_st = 2'd1; e_pw = branch_taken;
      end else if (branch_taken) begin
        e_pw = 1'b1;
      end else if (!icache_hit) begin
        e_pw = 1'b0;
      end else if (lw_stall) begin
        e_fl = 1'b0;
      end else begin
        e_pw = 1'b1; e_iw = 1'b1; e_fl = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dead <= 1'b0; m_refill <= 1'b0; m_age <= -1;
      m_stall_a <= 0; m_stall_b <= 0; m_miss_a <= 0; m_miss_b <= 0;
    end else begin
      if (!e_pw && !m_dead) begin
        m_stall_a <= (m_stall_a < MAXA) ? m_stall_a + 1 : MAXA;
        m_stall_b <= (m_stall_b < MAXB) ? m_stall_b + 1 : MAXB;
      end
      if (m_dead) begin
        m_dead <= 1'b1;
      end else if (m_refill) begin
        m_refill <= 1'b0;
      end else if (m_age >= 0) begin
        if (branch_taken)           m_age <= -1;
        else if (icache_ready)      begin m_age <= -1; m_refill <= 1'b1; end
        else if (m_age == TO - 1)   begin m_age <= -1; m_dead <= 1'b1; end
        else                        m_age <= m_age + 1;
      end else if (!branch_taken && !icache_hit) begin
        m_age <= 0;
        m_miss_a <= (m_miss_a < MAXA) ? m_miss_a + 1 : MAXA;
        m_miss_b <= (m_miss_b < MAXB) ? m_miss_b + 1 : MAXB;
      end
    end
  end

  always @(negedge clk) begin
    check("a.pc_write",   32'(pw_a),    32'(e_pw));
    check("a.ifid_write", 32'(iw_a),    32'(e_iw));
    check("a.ifid_flush", 32'(fl_a),    32'(e_fl));
    check("a.icache_req", 32'(req_a),   32'(e_req));
    check("a.fetch_err",  32'(err_a),   32'(e_err));
    check("a.state",      32'(st_a),    32'(e_st));
    check("a.stall_cnt",  32'(stall_a), 32'(m_stall_a));
    check("a.miss_cnt",   32'(miss_a),  32'(m_miss_a));
    check("b.pc_write",   32'(pw_b),    32'(e_pw));
    check("b.state",      32'(st_b),    32'(e_st));
    check("b.stall_cnt",  32'(stall_b), 32'(m_stall_b));
    check("b.miss_cnt",   32'(miss_b),  32'(m_miss_b));
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs just after a posedge and return mid-cycle so
  // the combinational outputs of that cycle can be inspected.
  task automatic step(input bit h, input bit r, input bit l, input bit b);
    @(posedge clk); #1;
    icache_hit = h; icache_ready = r; lw_stall = l; branch_taken = b;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icache_hit = 1'b1; icache_ready = 1'b0; lw_stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk); #1;
    check("rst.pc_write",   32'(pw_a),    32'd0);
    check("rst.ifid_write", 32'(iw_a),    32'd0);
    check("rst.ifid_flush", 32'(fl_a),    32'd1);
    check("rst.state",      32'(st_a),    32'd0);
    check("rst.stall_cnt",  32'(stall_a), 32'd0);
    check("rst.fetch_err",  32'(err_a),   32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel.pc_write", 32'(pw_a), 32'd1);
  endtask

  initial begin
    int req_cycles;

    do_reset();

    // Ten hit cycles with no hazards
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      check("hit.pc_write",   32'(pw_a), 32'd1);
      check("hit.ifid_write", 32'(iw_a), 32'd1);
      check("hit.state",      32'(st_a), 32'd0);
    end
    step(1, 0, 0, 0);
    check("hit.stall_cnt", 32'(stall_a), 32'd0);

    // Branch in RUN wins even over a miss
    step(0, 0, 0, 1);
    check("br.pc_write",   32'(pw_a), 32'd1);
    check("br.ifid_write", 32'(iw_a), 32'd0);
    check("br.ifid_flush", 32'(fl_a), 32'd1);
    step(1, 0, 0, 0);
    check("br.state", 32'(st_a), 32'd0);

    // One miss, ready on the fifth MISS cycle
    do_reset();
    step(0, 0, 0, 0);
    check("miss.pc_write", 32'(pw_a), 32'd0);
    check("miss.flush",    32'(fl_a), 32'd1);
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, (i == 4) ? 1'b1 : 1'b0, 0, 0);
      if (req_a) req_cycles++;
    end
    check("miss.req_cycles", 32'(req_cycles), 32'd5);
    step(1, 0, 0, 0);
    check("refill.state", 32'(st_a),  32'd2);
    check("refill.req",   32'(req_a), 32'd0);
    step(1, 0, 0, 0);
    check("resume.state",    32'(st_a),    32'd0);
    check("resume.pc_write", 32'(pw_a),    32'd1);
    check("miss.miss_cnt",   32'(miss_a),  32'd1);
    check("miss.stall_cnt",  32'(stall_a), 32'd7);
    check("model.stall7",    32'(m_stall_a), 32'd7);

    // Two-cycle load-use stall
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 0);
      check("lw.pc_write",   32'(pw_a), 32'd0);
      check("lw.ifid_write", 32'(iw_a), 32'd0);
      check("lw.ifid_flush", 32'(fl_a), 32'd0);
    end
    step(1, 0, 0, 0);
    check("lw.resume",    32'(iw_a),    32'd1);
    check("lw.stall_cnt", 32'(stall_a), 32'd2);

    // Branch coinciding with ready aborts the miss with no REFILL
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    check("brrdy.pc_write", 32'(pw_a), 32'd1);
    check("brrdy.flush",    32'(fl_a), 32'd1);
    check("brrdy.state",    32'(st_a), 32'd1);
    step(1, 0, 0, 0);
    check("brrdy.next_state", 32'(st_a),  32'd0);
    check("brrdy.req_drop",   32'(req_a), 32'd0);

    // Reset mid-MISS drops the request asynchronously
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("midrst.req_before", 32'(req_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.req",   32'(req_a), 32'd0);
    check("midrst.state", 32'(st_a),  32'd0);

    // Full timeout: the partial miss above must not shorten this one
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      step(1, 0, 0, 0);
      if (i == 0 || i == TO - 1) check("tmo.state_miss", 32'(st_a), 32'd1);
    end
    step(1, 0, 0, 0);
    check("tmo.state_err", 32'(st_a),  32'd3);
    check("tmo.fetch_err", 32'(err_a), 32'd1);
    check("tmo.req",       32'(req_a), 32'd0);
    step(1, 0, 0, 1);
    check("tmo.terminal",  32'(st_a),  32'd3);
    do_reset();
    check("tmo.rst_err",   32'(err_a), 32'd0);
    check("tmo.rst_state", 32'(st_a),  32'd0);

    // Saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    check("sat.stall_b", 32'(stall_b), 32'd15);
    check("sat.stall_a", 32'(stall_a), 32'd20);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    check("sat.hold_b",  32'(stall_b), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_id_ctrl
